// File: rtl/inst_rom_loader.sv
// Instruction ROM responder for the CPU fetch port, with a byte-serial loader that assembles
// big-endian words into the array. Fetches return NOP while a load session is running.
module inst_rom_loader #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [31:0]           rom_addr_i,
   output logic [31:0]           rom_data_o,
   input  logic                  ld_start_i,
   input  logic                  ld_valid_i,
   input  logic [7:0]            ld_byte_i,
   input  logic                  ld_last_i,
   output logic                  ld_ready_o,
   output logic                  ld_busy_o,
   output logic                  ld_done_o,
   output logic [DEPTH_LOG2:0]   ld_words_o,
   output logic                  ld_err_o
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PtrOne = 1;

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e                state_q, state_d;
   logic [1:0]            bcnt_q, bcnt_d;
   logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
   logic [DEPTH_LOG2:0]   words_q, words_d;
   logic                  err_q, err_d;
   logic [31:0]           asm_q, asm_d;

   logic [31:0]           mem [Depth];

   logic                  accept;
   logic                  word_end;
   logic                  full;
   logic                  mem_we;
   logic [31:0]           word_next;
   logic [DEPTH_LOG2-1:0] fetch_idx;
   logic                  fetch_hit;
   logic                  unused_addr;

   assign accept   = (state_q == StLoad) && ld_valid_i;
   assign word_end = accept && ((bcnt_q == 2'd3) || ld_last_i);
   // wptr never exceeds Depth, so its MSB alone marks the array as full.
   assign full     = wptr_q[DEPTH_LOG2];
   assign mem_we   = word_end && !full;

   always_comb begin
      word_next = asm_q;
      unique case (bcnt_q)
         2'd0: word_next[31:24] = ld_byte_i;
         2'd1: word_next[23:16] = ld_byte_i;
         2'd2: word_next[15:8]  = ld_byte_i;
         2'd3: word_next[7:0]   = ld_byte_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      wptr_d  = wptr_q;
      words_d = words_q;
      err_d   = err_q;
      asm_d   = asm_q;
      case (state_q)
         StIdle: begin
            if (ld_start_i) begin
               state_d = StLoad;
               bcnt_d  = '0;
               wptr_d  = '0;
               words_d = '0;
               err_d   = 1'b0;
               asm_d   = '0;
            end
         end
         StLoad: begin
            if (accept) begin
               if (word_end) begin
                  // Clearing the assembly register zero-pads any short final word.
                  bcnt_d = '0;
                  asm_d  = '0;
                  if (full) begin
                     err_d = 1'b1;
                  end else begin
                     wptr_d  = wptr_q + PtrOne;
                     words_d = words_q + PtrOne;
                  end
               end else begin
                  bcnt_d = bcnt_q + 2'd1;
                  asm_d  = word_next;
               end
               if (ld_last_i) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         bcnt_q  <= '0;
         wptr_q  <= '0;
         words_q <= '0;
         err_q   <= 1'b0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         wptr_q  <= wptr_d;
         words_q <= words_d;
         err_q   <= err_d;
         asm_q   <= asm_d;
      end
   end

   // The array is deliberately unreset so a reset does not wipe a loaded program.
   always_ff @(posedge clk) begin
      if (rst && mem_we) mem[wptr_q[DEPTH_LOG2-1:0]] <= word_next;
   end

   assign fetch_idx   = rom_addr_i[DEPTH_LOG2+1:2];
   assign fetch_hit   = rom_ce_i && (state_q != StLoad) && (rom_addr_i[31:DEPTH_LOG2+2] == '0);
   assign rom_data_o  = fetch_hit ? mem[fetch_idx] : 32'h0;
   assign unused_addr = ^rom_addr_i[1:0];

   assign ld_ready_o = (state_q == StLoad);
   assign ld_busy_o  = (state_q == StLoad);
   assign ld_done_o  = (state_q == StDone);
   assign ld_words_o = words_q;
   assign ld_err_o   = err_q;

endmodule
